// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage and the ROM it drives.
package instruction_fetch_unit_pkg;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } state_t;

  localparam int unsigned INST_BYTES        = 4;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam int unsigned ROM_BYTES_DEFAULT = 4096;

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter register: redirect load has priority over sequential increment.
module pc_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        inc,
  input  logic [31:0] load_pc,
  output logic [31:0] pc
);

  localparam logic [31:0] STEP = 32'(INST_BYTES);

  logic [31:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load)     pc_d = load_pc;
    else if (inc) pc_d = pc_q + STEP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the instruction ROM from pc, captures words into IR and
// hands them to decode over valid/ready; traps bad fetch addresses into ERR.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned ROM_BYTES = ROM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ir_ready,
  input  logic [31:0] D_In,
  output logic        m_cs,
  output logic        m_rd,
  output logic [31:0] Addr,
  output logic [31:0] IR,
  output logic        ir_valid,
  output logic [31:0] PC_Out,
  output logic [31:0] PC_Next,
  output logic        fetch_err
);

  localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - INST_BYTES);
  localparam logic [31:0] STEP    = 32'(INST_BYTES);

  state_t      state_q, state_d;
  logic [31:0] pc;
  logic [31:0] ir_d, ir_q, pc_out_d, pc_out_q, pc_next_d, pc_next_q;
  logic        ir_valid_d, ir_valid_q, fetch_err_d, fetch_err_q;
  logic        pc_bad, fetch_req, fire, trap, redirect_take;

  // A fetch is requested only when the IR slot is free or being drained;
  // the address check then decides between a ROM access and a trap.
  always_comb begin
    pc_bad        = (pc[1:0] != 2'b00) || (pc > LAST_PC);
    fetch_req     = (state_q == RUN) && en && !redirect && (!ir_valid_q || ir_ready);
    redirect_take = (state_q == RUN) && redirect;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == RUN) && fetch_req && pc_bad) state_d = ERR;
  end

  always_comb begin
    fire = 1'b0;
    trap = 1'b0;
    if (state_q == RUN) begin
      fire = fetch_req && !pc_bad;
      trap = fetch_req && pc_bad;
    end
  end

  assign m_cs = fire;
  assign m_rd = fire;
  assign Addr = pc;

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .rst    (reset),
    .load   (redirect_take),
    .inc    (fire),
    .load_pc(redirect_pc),
    .pc     (pc)
  );

  always_comb begin
    ir_d        = ir_q;
    pc_out_d    = pc_out_q;
    pc_next_d   = pc_next_q;
    ir_valid_d  = ir_valid_q;
    fetch_err_d = fetch_err_q | trap;
    if (redirect_take || trap) begin
      ir_valid_d = 1'b0;
    end else if (fire) begin
      ir_d       = D_In;
      pc_out_d   = pc;
      pc_next_d  = pc + STEP;
      ir_valid_d = 1'b1;
    end else if (ir_valid_q && ir_ready) begin
      ir_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q        <= '0;
      pc_out_q    <= '0;
      pc_next_q   <= STEP;
      ir_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      ir_q        <= ir_d;
      pc_out_q    <= pc_out_d;
      pc_next_q   <= pc_next_d;
      ir_valid_q  <= ir_valid_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign IR        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign PC_Out    = pc_out_q;
  assign PC_Next   = pc_next_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle table, ERR/reset sequences, and a
// scoreboarded stream up to the top of ROM with random decode back-pressure.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, redirect, ir_ready;
  logic [31:0] redirect_pc, D_In;
  logic        m_cs, m_rd, ir_valid, fetch_err;
  logic [31:0] Addr, IR, PC_Out, PC_Next;

  int unsigned total = 0;
  int unsigned passed = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0), .ROM_BYTES(4096)) dut (
    .clk(clk), .reset(reset), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .ir_ready(ir_ready), .D_In(D_In), .m_cs(m_cs), .m_rd(m_rd), .Addr(Addr), .IR(IR),
    .ir_valid(ir_valid), .PC_Out(PC_Out), .PC_Next(PC_Next), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [9:0] w;
    w = a[11:2];
    if (a >= 32'd4096) return 32'h0;
    case (w)
      10'd0:   return 32'h1111_1111;
      10'd1:   return 32'h2222_2222;
      10'd2:   return 32'h3333_3333;
      default: return 32'hC0DE_0000 | {22'b0, w};
    endcase
  endfunction

  always_comb D_In = rom_word(Addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  logic cs_s, rd_s;

  // Drive one cycle of inputs at negedge, capture ROM strobes before the edge.
  task automatic step(input logic e, input logic r, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    en = e; ir_ready = r; redirect = rd; redirect_pc = rpc;
    #1;
    cs_s = m_cs;
    rd_s = m_rd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; en = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1;
    chk("rst_addr", Addr, 32'h0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_valid", {31'b0, ir_valid}, 32'h0);
    chk("rst_pc_out", PC_Out, 32'h0);
    chk("rst_pc_next", PC_Next, 32'h4);
    chk("rst_err", {31'b0, fetch_err}, 32'h0);
    chk("rst_cs", {31'b0, m_cs}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        en, rdy, rd;
    logic [31:0] rpc;
    logic        cs;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ir, pc_out;
  } vec_t;

  function automatic vec_t mkv(input logic e, input logic r, input logic rd, input logic [31:0] rpc,
                               input logic cs, input logic [31:0] addr, input logic v,
                               input logic [31:0] ir, input logic [31:0] po);
    vec_t x;
    x.en = e; x.rdy = r; x.rd = rd; x.rpc = rpc; x.cs = cs;
    x.addr = addr; x.valid = v; x.ir = ir; x.pc_out = po;
    return x;
  endfunction

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  vec_t vt[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    int unsigned viol;
    bit          done;

    vt[0]  = mkv(1, 1, 0, 32'h0,   1, 32'h004, 1, 32'h1111_1111, 32'h000);
    vt[1]  = mkv(1, 1, 0, 32'h0,   1, 32'h008, 1, 32'h2222_2222, 32'h004);
    vt[2]  = mkv(1, 1, 0, 32'h0,   1, 32'h00C, 1, 32'h3333_3333, 32'h008);
    vt[3]  = mkv(1, 0, 0, 32'h0,   0, 32'h00C, 1, 32'h3333_3333, 32'h008);
    vt[4]  = mkv(1, 0, 0, 32'h0,   0, 32'h00C, 1, 32'h3333_3333, 32'h008);
    vt[5]  = mkv(1, 0, 0, 32'h0,   0, 32'h00C, 1, 32'h3333_3333, 32'h008);
    vt[6]  = mkv(1, 1, 0, 32'h0,   1, 32'h010, 1, 32'hC0DE_0003, 32'h00C);
    vt[7]  = mkv(1, 0, 1, 32'h100, 0, 32'h100, 0, 32'hC0DE_0003, 32'h00C);
    vt[8]  = mkv(1, 1, 0, 32'h0,   1, 32'h104, 1, 32'hC0DE_0040, 32'h100);
    vt[9]  = mkv(1, 1, 1, 32'h200, 0, 32'h200, 0, 32'hC0DE_0040, 32'h100);
    vt[10] = mkv(1, 1, 0, 32'h0,   1, 32'h204, 1, 32'hC0DE_0080, 32'h200);
    vt[11] = mkv(0, 1, 0, 32'h0,   0, 32'h204, 0, 32'hC0DE_0080, 32'h200);
    vt[12] = mkv(0, 0, 0, 32'h0,   0, 32'h204, 0, 32'hC0DE_0080, 32'h200);
    vt[13] = mkv(1, 0, 0, 32'h0,   1, 32'h208, 1, 32'hC0DE_0081, 32'h204);

    reset = 1'b1; en = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Sequential fetch, stall, redirects, consume-without-fire.
    for (int i = 0; i < 14; i++) begin
      step(vt[i].en, vt[i].rdy, vt[i].rd, vt[i].rpc);
      chk($sformatf("v%0d_cs", i), {31'b0, cs_s}, {31'b0, vt[i].cs});
      chk($sformatf("v%0d_rd", i), {31'b0, rd_s}, {31'b0, vt[i].cs});
      chk($sformatf("v%0d_addr", i), Addr, vt[i].addr);
      chk($sformatf("v%0d_valid", i), {31'b0, ir_valid}, {31'b0, vt[i].valid});
      chk($sformatf("v%0d_ir", i), IR, vt[i].ir);
      chk($sformatf("v%0d_pc_out", i), PC_Out, vt[i].pc_out);
      chk($sformatf("v%0d_pc_next", i), PC_Next, vt[i].pc_out + 32'd4);
      chk($sformatf("v%0d_err", i), {31'b0, fetch_err}, 32'h0);
    end

    // Asynchronous reset while stalled on a valid IR: no clock edge needed.
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_valid", {31'b0, ir_valid}, 32'h0);
    chk("async_ir", IR, 32'h0);
    chk("async_addr", Addr, 32'h0);
    chk("async_pc_next", PC_Next, 32'h4);
    do_reset();

    // Misaligned redirect traps; ERR ignores redirect until reset.
    step(1, 1, 1, 32'h102);
    chk("mis_redir_cs", {31'b0, cs_s}, 32'h0);
    chk("mis_addr", Addr, 32'h102);
    chk("mis_err_pre", {31'b0, fetch_err}, 32'h0);
    step(1, 1, 0, 32'h0);
    chk("mis_trap_cs", {31'b0, cs_s}, 32'h0);
    chk("mis_err", {31'b0, fetch_err}, 32'h1);
    chk("mis_valid", {31'b0, ir_valid}, 32'h0);
    step(1, 1, 1, 32'h0);
    chk("err_redir_cs", {31'b0, cs_s}, 32'h0);
    chk("err_redir_addr", Addr, 32'h102);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 32'h0);
      chk($sformatf("err_idle%0d_cs", i), {31'b0, cs_s}, 32'h0);
      chk($sformatf("err_idle%0d_err", i), {31'b0, fetch_err}, 32'h1);
    end
    do_reset();
    step(1, 1, 0, 32'h0);
    chk("post_err_cs", {31'b0, cs_s}, 32'h1);
    chk("post_err_ir", IR, 32'h1111_1111);

    // Stream to the top of ROM under random back-pressure, scoreboarded.
    do_reset();
    step(1, 0, 1, 32'hF00);
    for (int unsigned a = 32'hF00; a <= 32'hFFC; a += 4) begin
      e.ir = rom_word(a);
      e.pc = a;
      sb.push_back(e);
    end
    viol = 0;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      en = 1'b1; redirect = 1'b0; ir_ready = 1'($urandom_range(0, 1));
      #1;
      if (m_cs && ir_valid && !ir_ready) viol++;
      if (m_cs && (Addr > 32'hFFC)) viol++;
      if (ir_valid && ir_ready) begin
        if (sb.size() == 0) begin
          chk("sb_extra_pc", PC_Out, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("sb_ir", IR, e.ir);
          chk("sb_pc_out", PC_Out, e.pc);
          chk("sb_pc_next", PC_Next, e.pc + 32'd4);
        end
      end
      @(posedge clk);
      #1;
      if (fetch_err) done = 1'b1;
    end
    chk("top_reached", {31'b0, done}, 32'h1);
    chk("top_sb_empty", sb.size(), 32'h0);
    chk("top_addr", Addr, 32'h1000);
    chk("top_valid", {31'b0, ir_valid}, 32'h0);
    chk("top_violations", viol, 32'h0);
    step(1, 1, 0, 32'h0);
    chk("top_err_cs", {31'b0, cs_s}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the byte-addressed, big-endian 4 KB instruction ROM. It owns the program counter, drives the ROM chip-select, read and address, and captures the returned 32-bit word into an instruction register (IR). The IR is presented to decode through a valid/ready handshake. It also accepts branch/jump redirects and traps misaligned or out-of-range fetch addresses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ROM_BYTES, 4096, ROM size in bytes; highest legal fetch address is ROM_BYTES-4.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  fetch enable; when low, no new fetch is issued.
redirect  input  1  load redirect_pc as the next fetch address; flushes IR.
redirect_pc  input  32  branch/jump target, byte address.
ir_ready  input  1  decode accepts the IR this cycle.
D_In  input  32  ROM read data, combinational from Addr.
m_cs  output  1  ROM chip select.
m_rd  output  1  ROM read strobe.
Addr  output  32  ROM byte address; always equals pc.
IR  output  32  captured instruction word.
ir_valid  output  1  IR holds an unconsumed instruction.
PC_Out  output  32  address of the instruction in IR.
PC_Next  output  32  PC_Out + 4, used for link.
fetch_err  output  1  sticky error flag: misaligned or out-of-range fetch.

Behaviour:
- Reset (async, active-high) values: pc=RESET_PC, IR=0, ir_valid=0, PC_Out=0, PC_Next=4, fetch_err=0, state=RUN.
- States are RUN and ERR. ERR is left only by reset.
- Fetch condition: fire = (state==RUN) && en && !redirect && (!ir_valid || ir_ready).
- m_cs = m_rd = fire, combinational. Both are 0 in every other cycle.
- Addr = pc at all times.
- On a fire edge:
  - IR <= D_In, PC_Out <= pc, PC_Next <= pc+4, ir_valid <= 1, pc <= pc+4.
- Latency and throughput:
  - Latency is 1 cycle from fire to a valid IR.
  - Throughput is 1 instruction/cycle while ir_ready is held high.
- Consume without fire: ir_valid && ir_ready && !fire → ir_valid <= 0 (e.g. en low).
- Stall: ir_valid && !ir_ready → IR, PC_Out, PC_Next and pc are all held, and m_cs stays 0.
- Redirect:
  - Takes priority over fire and over consume.
  - Edge effect: ir_valid <= 0 and pc <= redirect_pc.
  - The first fetch from the new pc happens on the following cycle.
  - An IR being handed to decode in the redirect cycle is dropped. Decode is responsible for not issuing a redirect and an ir_ready for the same younger instruction.
- Error check, evaluated on the pc about to be fetched in RUN: (pc[1:0]!=0) || (pc > ROM_BYTES-4).
  - If it fails, fire is suppressed.
  - state <= ERR, fetch_err <= 1, ir_valid <= 0.
- In ERR, no fetches are issued and redirect is ignored.
- pc arithmetic is unsigned mod 2^32. Sequential wrap past ROM_BYTES-4 is caught by the range check, not wrapped.
- Reset mid-stall or mid-redirect: everything returns to reset values immediately (asynchronous).

Decomposition:
- Shared package holds:
  - RUN/ERR state encoding.
  - INST_BYTES=4.
  - Default RESET_PC.
  - The ROM_BYTES constant shared with the ROM.
- One natural sub-module: pc_register, holding pc with async reset and a load/increment select (redirect, +4, hold).
- The FSM and IR stay in the top level.

Test Plan:
1. Reset release, en=1, ir_ready=1, ROM words 0x11111111/0x22222222/0x33333333 at bytes 0/4/8 → IR follows those words on cycles 1/2/3; PC_Out=0,4,8; PC_Next=4,8,12; m_cs high every cycle.
2. ir_ready low for 3 cycles after the first IR → IR=0x11111111 and Addr=4 held, m_cs=0; fetch of 4 resumes the cycle ready returns.
3. redirect=1 with redirect_pc=0x100 while ir_valid=1 → next cycle ir_valid=0 and Addr=0x100; following cycle IR=mem[0x100..0x103] and PC_Out=0x100.
4. Simultaneous redirect and ir_ready with en=1 → no fetch in that cycle (m_cs=0); redirect target is fetched next.
5. redirect_pc=0x102 → fetch_err=1, state ERR, m_cs never asserted again; a later redirect to 0x0 is ignored until reset clears fetch_err.
6. pc reaches 0xFFC → fetch of 0xFFC succeeds; next pc=0x1000 sets fetch_err=1 with no ROM access.
